// File: rtl/sprite_line_scheduler_pkg.sv
// Shared types and defaults for the sprite line scheduler.
package sprite_line_scheduler_pkg;

    localparam int DEF_NUM_SPRITES = 4;
    localparam int DEF_SPR_H       = 16;
    localparam int DEF_SPR_W       = 16;
    localparam int DEF_ADDR_W      = 6;
    localparam int DEF_Y_W         = 10;
    localparam int DEF_TIMEOUT     = 15;

    // A pixel of all-zero colour bits is drawn as transparent by the pixel mux.
    localparam logic [2:0] PIX_TRANSPARENT = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_REQ   = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Width of an index/counter for n items, never narrower than one bit.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_line_scheduler_if.sv
// ROM read port and line-buffer write port of the sprite line scheduler.
//
// Handshake: the master pulses rom_rd for exactly one cycle and holds rom_addr
// until the slave returns rom_valid (a one-cycle pulse, at least one cycle
// after rom_rd, with rom_data valid in that same cycle) or until the master
// gives up. There is no ready/backpressure: rom_valid while no read is
// outstanding is ignored. lb_we is one-hot for one cycle; lb_data is valid
// only in that cycle and reads as zero otherwise.
interface sprite_line_scheduler_if #(
    parameter int NUM_SPRITES = 4,
    parameter int SPR_W       = 16,
    parameter int ADDR_W      = 6
);
    logic                   rom_rd;
    logic [ADDR_W-1:0]      rom_addr;
    logic                   rom_valid;
    logic [SPR_W*3-1:0]     rom_data;
    logic [NUM_SPRITES-1:0] lb_we;
    logic [SPR_W*3-1:0]     lb_data;

    modport master (
        output rom_rd, rom_addr, lb_we, lb_data,
        input  rom_valid, rom_data
    );

    modport slave (
        input  rom_rd, rom_addr, lb_we, lb_data,
        output rom_valid, rom_data
    );
endinterface

// File: rtl/sprite_line_scheduler_row_hit.sv
// Decides whether a sprite covers a given line and which of its rows it is.
module sprite_line_scheduler_row_hit #(
    parameter int Y_W   = 10,
    parameter int SPR_H = 16,
    parameter int ROW_W = 4
) (
    input  logic             en_i,
    input  logic [Y_W-1:0]   line_i,
    input  logic [Y_W-1:0]   top_i,
    output logic             hit_o,
    output logic [ROW_W-1:0] row_o
);
    logic [Y_W:0] diff;

    // Unsigned difference one bit wider: a top below the line wraps large and misses.
    always_comb begin
        diff  = {1'b0, line_i} - {1'b0, top_i};
        hit_o = en_i && (diff < (Y_W+1)'(SPR_H));
        row_o = diff[ROW_W-1:0];
    end
endmodule

// File: rtl/sprite_line_scheduler.sv
// Walks the sprites during hblank and copies each one's next-line row from the
// shared sprite ROM into its line buffer (zero row for sprites not on the line).
module sprite_line_scheduler
    import sprite_line_scheduler_pkg::*;
#(
    parameter int NUM_SPRITES = DEF_NUM_SPRITES,
    parameter int SPR_H       = DEF_SPR_H,
    parameter int SPR_W       = DEF_SPR_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int Y_W         = DEF_Y_W,
    parameter int TIMEOUT     = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     hblank_start,
    input  logic [Y_W-1:0]           next_line,
    input  logic [NUM_SPRITES-1:0]   sprite_en,
    input  logic [NUM_SPRITES*Y_W-1:0] sprite_y,
    sprite_line_scheduler_if.master  bus,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun,
    output state_e                   dbg_state
);
    localparam int IDX_W = clog2_min1(NUM_SPRITES);
    localparam int ROW_W = clog2_min1(SPR_H);
    localparam int CNT_W = clog2_min1(TIMEOUT + 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_SPRITES - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [SPR_W*3-1:0] ZERO_ROW = {SPR_W{PIX_TRANSPARENT}};

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [SPR_W*3-1:0] row_q, row_d;
    logic               ovr_q, ovr_d;

    logic               hit;
    logic [ROW_W-1:0]   hit_row;
    logic               timeout_hit;

    // Hit test on the sprite currently selected by idx; inputs are live, not captured.
    sprite_line_scheduler_row_hit #(
        .Y_W   (Y_W),
        .SPR_H (SPR_H),
        .ROW_W (ROW_W)
    ) u_row_hit (
        .en_i   (sprite_en[idx_q]),
        .line_i (next_line),
        .top_i  (sprite_y[idx_q*Y_W +: Y_W]),
        .hit_o  (hit),
        .row_o  (hit_row)
    );

    assign timeout_hit = (state_q == ST_WAIT) && !bus.rom_valid && (cnt_q == CNT_LAST);

    // State register; asynchronous reset aborts any fetch in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (hblank_start) state_d = ST_CHECK;
            ST_CHECK: state_d = hit ? ST_REQ : ST_WRITE;
            ST_REQ:   state_d = ST_WAIT;
            ST_WAIT:  if (bus.rom_valid || timeout_hit) state_d = ST_WRITE;
            ST_WRITE: state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_CHECK;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Datapath registers: sprite index, wait counter, address, row and sticky overrun.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            addr_q <= '0;
            row_q  <= '0;
            ovr_q  <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            addr_q <= addr_d;
            row_q  <= row_d;
            ovr_q  <= ovr_d;
        end
    end

    // Datapath next values; a miss or a timeout leaves the zero row in place.
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        addr_d = addr_q;
        row_d  = row_q;
        ovr_d  = ovr_q | (hblank_start && (state_q != ST_IDLE)) | timeout_hit;
        case (state_q)
            ST_CHECK: begin
                row_d = ZERO_ROW;
                cnt_d = '0;
                if (hit) addr_d = ADDR_W'(int'(idx_q) * SPR_H + int'(hit_row));
            end
            ST_WAIT: begin
                if (bus.rom_valid)     row_d = bus.rom_data;
                else if (!timeout_hit) cnt_d = cnt_q + 1'b1;
            end
            ST_WRITE: idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            default: ;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        bus.rom_rd   = (state_q == ST_REQ);
        bus.rom_addr = addr_q;
        bus.lb_we    = (state_q == ST_WRITE) ? (NUM_SPRITES'(1) << idx_q) : '0;
        bus.lb_data  = (state_q == ST_WRITE) ? row_q : '0;
        busy         = (state_q != ST_IDLE);
        done         = (state_q == ST_DONE);
        overrun      = ovr_q;
        dbg_state    = state_q;
    end
endmodule

// File: tb/tb_sprite_line_scheduler.sv
// Directed bench for the sprite line scheduler with a latency-programmable ROM model.
module tb_sprite_line_scheduler;
    import sprite_line_scheduler_pkg::*;

    localparam int NS = 4;
    localparam int SW = 16;
    localparam int SH = 16;
    localparam int AW = 6;
    localparam int YW = 10;
    localparam int TO = 15;
    localparam int W  = NS + SW*3;

    logic            clk = 1'b0;
    logic            reset;
    logic            hblank_start;
    logic [YW-1:0]   next_line;
    logic [NS-1:0]   sprite_en;
    logic [NS*YW-1:0] sprite_y;
    logic            busy, done, overrun;
    state_e          dbg_state;

    sprite_line_scheduler_if #(.NUM_SPRITES(NS), .SPR_W(SW), .ADDR_W(AW)) bus();

    sprite_line_scheduler #(
        .NUM_SPRITES(NS), .SPR_H(SH), .SPR_W(SW), .ADDR_W(AW), .Y_W(YW), .TIMEOUT(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .hblank_start (hblank_start),
        .next_line    (next_line),
        .sprite_en    (sprite_en),
        .sprite_y     (sprite_y),
        .bus          (bus),
        .busy         (busy),
        .done         (done),
        .overrun      (overrun),
        .dbg_state    (dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    int rd_cnt = 0, done_cnt = 0, lb_cnt = 0, done_cyc = 0, hb_cyc = 0;
    logic [AW-1:0] rd_addr = '0;

    int rom_lat = 1;
    bit rom_mute = 1'b0;
    int rom_pend = 0;
    logic [AW-1:0] rom_a = '0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [SW*3-1:0] rom_word(input logic [AW-1:0] a);
        return {8{a}};
    endfunction

    // ROM model: answers a read rom_lat cycles after the strobe unless muted
    initial begin
        bus.rom_valid = 1'b0;
        bus.rom_data  = '0;
        forever begin
            @(posedge clk); #1;
            bus.rom_valid = 1'b0;
            if (rom_pend > 0) begin
                rom_pend--;
                if (rom_pend == 0) begin
                    bus.rom_valid = 1'b1;
                    bus.rom_data  = rom_word(rom_a);
                end
            end else if (bus.rom_rd === 1'b1 && !rom_mute) begin
                rom_pend = rom_lat;
                rom_a    = bus.rom_addr;
            end
        end
    end

    // Monitor / scoreboard on the falling edge
    always @(negedge clk) begin
        if (bus.lb_we !== '0) begin
            lb_cnt++;
            if (exp_q.size() == 0) check("lb_extra", {bus.lb_we, bus.lb_data}, '0);
            else                   check("lb_write", {bus.lb_we, bus.lb_data}, exp_q.pop_front());
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (bus.rom_rd === 1'b1) begin
            rd_cnt++;
            rd_addr = bus.rom_addr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        hblank_start = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic clr_stats();
        rd_cnt = 0; done_cnt = 0; lb_cnt = 0;
        exp_q.delete();
    endtask

    task automatic set_y(input int idx, input int y);
        sprite_y[idx*YW +: YW] = YW'(y);
    endtask

    task automatic expect_row(input int idx, input logic [SW*3-1:0] data);
        logic [NS-1:0] we;
        we = NS'(1) << idx;
        exp_q.push_back({we, data});
    endtask

    task automatic expect_zero_rows();
        for (int i = 0; i < NS; i++) expect_row(i, '0);
    endtask

    task automatic pulse_hb();
        hblank_start = 1'b1;
        hb_cyc = cyc;
        tick(1);
        hblank_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int start = done_cnt;
        int i = 0;
        while (done_cnt == start && i < budget) begin tick(1); i++; end
        check("done_seen", 64'(done_cnt != start), 64'd1);
    endtask

    task automatic end_frame(input string tag, input int t0, input int delta, input int rds);
        tick(2);
        check({tag, "_latency"}, 64'(done_cyc - t0), 64'(delta));
        check({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
        check({tag, "_rom_rd_cnt"}, 64'(rd_cnt), 64'(rds));
        check({tag, "_lb_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        int t0;
        reset = 1'b0; hblank_start = 1'b0; next_line = '0; sprite_en = '0; sprite_y = '0;
        tick(3);
        check("rst_busy",    64'(busy), 0);
        check("rst_done",    64'(done), 0);
        check("rst_overrun", 64'(overrun), 0);
        check("rst_rom_rd",  64'(bus.rom_rd), 0);
        check("rst_rom_addr",64'(bus.rom_addr), 0);
        check("rst_lb_we",   64'(bus.lb_we), 0);
        check("rst_lb_data", 64'(bus.lb_data), 0);
        check("rst_state",   64'(dbg_state), 64'(ST_IDLE));
        reset = 1'b1;
        tick(2);

        // All sprites disabled: four zero rows, done 9 cycles after hblank_start
        clr_stats(); expect_zero_rows();
        pulse_hb(); t0 = hb_cyc;
        wait_done(40);
        end_frame("all_miss", t0, 9, 0);
        check("all_miss_overrun", 64'(overrun), 0);

        // Sprite 1 at y=100, line 105, ROM latency 2 -> addr 21
        clr_stats();
        sprite_en = 4'b0010; set_y(1, 100); next_line = 10'd105; rom_lat = 2;
        expect_row(0, '0); expect_row(1, rom_word(6'd21)); expect_row(2, '0); expect_row(3, '0);
        pulse_hb(); t0 = hb_cyc;
        wait_done(40);
        end_frame("hit1", t0, 12, 1);
        check("hit1_addr", 64'(rd_addr), 64'd21);

        // Last row of sprite 1 (addr 31) and row 5 of sprite 3 (addr 53), latency 1
        clr_stats();
        sprite_en = 4'b1010; set_y(3, 110); next_line = 10'd115; rom_lat = 1;
        expect_row(0, '0); expect_row(1, rom_word(6'd31)); expect_row(2, '0); expect_row(3, rom_word(6'd53));
        pulse_hb(); t0 = hb_cyc;
        wait_done(40);
        end_frame("row15", t0, 13, 2);
        check("row15_last_addr", 64'(rd_addr), 64'd53);

        // One line past the sprite bottom -> miss
        clr_stats();
        sprite_en = 4'b0010; next_line = 10'd116;
        expect_zero_rows();
        pulse_hb(); t0 = hb_cyc;
        wait_done(40);
        end_frame("row16", t0, 9, 0);

        // Sprite top below the line: difference wraps, no hit
        clr_stats();
        set_y(1, 200); next_line = 10'd5;
        expect_zero_rows();
        pulse_hb(); t0 = hb_cyc;
        wait_done(40);
        end_frame("wrap", t0, 9, 0);
        check("wrap_overrun", 64'(overrun), 0);

        // ROM never answers sprite 0: 15 wait cycles, zero row, overrun, others still served
        clr_stats();
        sprite_en = 4'b0001; set_y(0, 0); next_line = 10'd3; rom_mute = 1'b1;
        expect_zero_rows();
        pulse_hb(); t0 = hb_cyc;
        wait_done(60);
        end_frame("timeout", t0, 25, 1);
        check("timeout_addr", 64'(rd_addr), 64'd3);
        check("timeout_overrun", 64'(overrun), 1);
        rom_mute = 1'b0;
        do_reset();
        check("reset_clears_overrun", 64'(overrun), 0);

        // Second hblank_start 3 cycles after the first is ignored
        clr_stats();
        sprite_en = '0;
        expect_zero_rows();
        pulse_hb(); t0 = hb_cyc;
        tick(2);
        pulse_hb();
        wait_done(40);
        end_frame("double", t0, 9, 0);
        check("double_overrun", 64'(overrun), 1);
        tick(15);
        check("double_no_restart_done", 64'(done_cnt), 1);
        check("double_lb_cnt", 64'(lb_cnt), 4);

        // hblank_start in the DONE cycle is ignored
        do_reset();
        clr_stats();
        expect_zero_rows();
        pulse_hb(); t0 = hb_cyc;
        tick(8);
        pulse_hb();
        end_frame("in_done", t0, 9, 0);
        check("in_done_overrun", 64'(overrun), 1);
        tick(15);
        check("in_done_no_restart", 64'(lb_cnt), 4);

        // Reset asserted while waiting on the ROM for sprite 2
        do_reset();
        clr_stats();
        sprite_en = 4'b0100; set_y(2, 50); next_line = 10'd53; rom_mute = 1'b1;
        expect_row(0, '0); expect_row(1, '0);
        pulse_hb();
        for (int i = 0; i < 20 && dbg_state != ST_WAIT; i++) tick(1);
        check("mid_reach_wait", 64'(dbg_state), 64'(ST_WAIT));
        tick(2);
        reset = 1'b0;
        #2;
        check("mid_busy",   64'(busy), 0);
        check("mid_lb_we",  64'(bus.lb_we), 0);
        check("mid_rom_rd", 64'(bus.rom_rd), 0);
        check("mid_state",  64'(dbg_state), 64'(ST_IDLE));
        tick(3);
        reset = 1'b1;
        tick(25);
        check("mid_no_done", 64'(done_cnt), 0);
        check("mid_lb_cnt",  64'(lb_cnt), 2);
        check("mid_lb_left", 64'(exp_q.size()), 0);
        check("mid_idle",    64'(busy), 0);
        rom_mute = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
